stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl_if.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
// Control pulses and display-side signals of the stopwatch controller.
//   start_stop, lap, clear : single-cycle synchronous control pulses
//   hex3..hex0             : BCD digits M, S-tens, S-units, tenths
//   dp_out                 : active-low decimal points, bit i = digit i
//   run                    : high while counting (RUN or LAP)
//   ovf                    : sticky 9:59.9 -> 0:00.0 wrap flag
// master = pulse source / display consumer, slave = the controller.
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] hex3;
  logic [3:0] hex2;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic [3:0] dp_out;
  logic       run;
  logic       ovf;

  modport master (
    output start_stop, lap, clear,
    input  hex3, hex2, hex1, hex0, dp_out, run, ovf
  );

  modport slave (
    input  start_stop, lap, clear,
    output hex3, hex2, hex1, hex0, dp_out, run, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencing controller for a four-digit M:SS.d stopwatch display.
// Prescales clk to a 0.1 s tick, keeps a BCD count, and supports a lap mode
// that freezes the display while counting continues underneath.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   sw    : control pulses in, display digits / dp / run / ovf out
// Parameters: TICK_DIV clk cycles per tick (>= 2), PW prescaler width.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned PW       = 23
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.slave   sw
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_LAP    = 2'd3
  } state_t;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  // BCD cascade increment of {d3,d2,d1,d0}; bit 16 flags the 9:59.9 wrap.
  function automatic logic [16:0] bcd_inc(input logic [15:0] c);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       wrap;
    d0   = c[3:0];
    d1   = c[7:4];
    d2   = c[11:8];
    d3   = c[15:12];
    wrap = 1'b0;
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        if (d2 == 4'd5) begin
          d2 = 4'd0;
          if (d3 == 4'd9) begin
            d3   = 4'd0;
            wrap = 1'b1;
          end else begin
            d3 = d3 + 4'd1;
          end
        end else begin
          d2 = d2 + 4'd1;
        end
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {wrap, d3, d2, d1, d0};
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PW-1:0]  r_presc;
  logic [15:0]    r_count;
  logic [15:0]    r_lap;
  logic           r_ovf;

  logic           w_counting;
  logic           w_tick;
  logic [16:0]    w_inc;
  logic           w_cap;      // lap capture on this edge
  logic           w_zero;     // PAUSED clear: zero count and prescaler
  logic           w_ovf_clr;

  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_presc == TICK_LAST);
  assign w_inc      = bcd_inc(r_count);

  // Next-state decode; the if/else chains encode clear > start_stop > lap
  // among the pulses that are legal in each state.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_zero      = 1'b0;
    w_ovf_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sw.clear) begin
          w_ovf_clr = 1'b1;
        end else if (sw.start_stop) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (sw.start_stop) begin
          w_state_nxt = S_PAUSED;
        end else if (sw.lap) begin
          w_state_nxt = S_LAP;
          w_cap       = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_LAP: begin
        if (sw.start_stop) begin
          w_state_nxt = S_PAUSED;
        end else if (sw.lap) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_LAP;
        end
      end
      S_PAUSED: begin
        if (sw.clear) begin
          w_state_nxt = S_IDLE;
          w_zero      = 1'b1;
          w_ovf_clr   = 1'b1;
        end else if (sw.start_stop) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_PAUSED;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prescaler: runs in RUN/LAP (including the cycle a pause is requested),
  // held in PAUSED so a resume continues the partial tenth, zero in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_zero) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= w_tick ? '0 : (r_presc + PW'(1));
    end else if (r_state == S_IDLE) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc;
    end
  end

  // BCD count; ticks only occur in RUN/LAP so they never meet a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 16'h0000;
    end else if (w_zero) begin
      r_count <= 16'h0000;
    end else if (w_tick) begin
      r_count <= w_inc[15:0];
    end else begin
      r_count <= r_count;
    end
  end

  // Lap latch takes the pre-increment count even when a tick coincides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lap <= 16'h0000;
    end else if (w_cap) begin
      r_lap <= r_count;
    end else begin
      r_lap <= r_lap;
    end
  end

  // Sticky wrap flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end else if (w_tick && w_inc[16]) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign sw.hex3   = (r_state == S_LAP) ? r_lap[15:12] : r_count[15:12];
  assign sw.hex2   = (r_state == S_LAP) ? r_lap[11:8]  : r_count[11:8];
  assign sw.hex1   = (r_state == S_LAP) ? r_lap[7:4]   : r_count[7:4];
  assign sw.hex0   = (r_state == S_LAP) ? r_lap[3:0]   : r_count[3:0];
  assign sw.dp_out = (r_state == S_LAP) ? 4'b0100 : 4'b0101;
  assign sw.run    = w_counting;
  assign sw.ovf    = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV = 4.
// Expected display values are hand-computed BCD words {hex3,hex2,hex1,hex0}.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4), .PW(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  logic [15:0] w_disp;
  assign w_disp = {sw_if.hex3, sw_if.hex2, sw_if.hex1, sw_if.hex0};

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ss, input logic lp, input logic cl);
    sw_if.start_stop = ss;
    sw_if.lap        = lp;
    sw_if.clear      = cl;
    @(posedge clk);
    #1;
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clear      = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clear      = 1'b0;
    reset            = 1'b0;

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_val("rst_disp", w_disp, 16'h0000);
    chk_val("rst_dp",   {12'h000, sw_if.dp_out}, 16'h0005);
    chk_val("rst_run",  {15'h0000, sw_if.run}, 16'h0000);
    chk_val("rst_ovf",  {15'h0000, sw_if.ovf}, 16'h0000);

    // lap in IDLE is ignored
    pulse(1'b0, 1'b1, 1'b0);
    chk_val("idle_lap_dp",  {12'h000, sw_if.dp_out}, 16'h0005);
    chk_val("idle_lap_run", {15'h0000, sw_if.run}, 16'h0000);

    // 2. start and count
    pulse(1'b1, 1'b0, 1'b0);
    chk_val("start_run", {15'h0000, sw_if.run}, 16'h0001);
    step(40);
    chk_val("run_1s", w_disp, 16'h0010);
    step(560);
    chk_val("run_15s", w_disp, 16'h0150);

    // 3. pause with prescaler held at 2, resume
    step(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk_val("pause_run", {15'h0000, sw_if.run}, 16'h0000);
    step(20);
    chk_val("pause_frozen", w_disp, 16'h0150);
    pulse(1'b1, 1'b0, 1'b0);
    step(1);
    chk_val("resume_pre", w_disp, 16'h0150);
    step(1);
    chk_val("resume_tick", w_disp, 16'h0151);

    // 4. lap mode from a fresh count of 0:03.7
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_val("clr_paused", w_disp, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    step(148);
    chk_val("at_3_7", w_disp, 16'h0037);
    pulse(1'b0, 1'b1, 1'b0);
    chk_val("lap_dp", {12'h000, sw_if.dp_out}, 16'h0004);
    step(39);
    chk_val("lap_frozen", w_disp, 16'h0037);
    chk_val("lap_run", {15'h0000, sw_if.run}, 16'h0001);
    pulse(1'b0, 1'b1, 1'b0);
    chk_val("lap_live", w_disp, 16'h0047);
    chk_val("lap_live_dp", {12'h000, sw_if.dp_out}, 16'h0005);

    // lap capture coinciding with a tick keeps the pre-increment value
    step(2);
    pulse(1'b0, 1'b1, 1'b0);
    chk_val("lap_tick", w_disp, 16'h0047);
    pulse(1'b1, 1'b0, 1'b0);
    chk_val("lap_to_pause", w_disp, 16'h0048);
    chk_val("lap_to_pause_dp", {12'h000, sw_if.dp_out}, 16'h0005);
    // tick and start_stop together: count advances and pauses
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    pulse(1'b1, 1'b0, 1'b0);
    chk_val("tick_ss", w_disp, 16'h0049);
    chk_val("tick_ss_run", {15'h0000, sw_if.run}, 16'h0000);

    // 5. wrap, ovf, clear ignored in RUN
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    step(40);
    pulse(1'b0, 1'b0, 1'b1);
    chk_val("run_clear_ign", w_disp, 16'h0010);
    chk_val("run_clear_run", {15'h0000, sw_if.run}, 16'h0001);
    step(23955);
    chk_val("at_9599", w_disp, 16'h9599);
    chk_val("pre_wrap_ovf", {15'h0000, sw_if.ovf}, 16'h0000);
    step(4);
    chk_val("wrap_disp", w_disp, 16'h0000);
    chk_val("wrap_ovf", {15'h0000, sw_if.ovf}, 16'h0001);
    chk_val("wrap_run", {15'h0000, sw_if.run}, 16'h0001);
    pulse(1'b1, 1'b0, 1'b0);
    chk_val("pause_ovf", {15'h0000, sw_if.ovf}, 16'h0001);
    pulse(1'b0, 1'b0, 1'b1);
    chk_val("clr_ovf", {15'h0000, sw_if.ovf}, 16'h0000);
    chk_val("clr_run", {15'h0000, sw_if.run}, 16'h0000);

    // 6. clear beats start_stop in PAUSED
    pulse(1'b1, 1'b0, 1'b0);
    step(5);
    chk_val("restart", w_disp, 16'h0001);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    chk_val("clr_wins_disp", w_disp, 16'h0000);
    chk_val("clr_wins_run", {15'h0000, sw_if.run}, 16'h0000);
    step(4);
    chk_val("idle_hold", w_disp, 16'h0000);

    // asynchronous reset mid-RUN, between edges
    pulse(1'b1, 1'b0, 1'b0);
    step(10);
    chk_val("pre_areset", w_disp, 16'h0002);
    #2;
    reset = 1'b0;
    #1;
    chk_val("areset_disp", w_disp, 16'h0000);
    chk_val("areset_run", {15'h0000, sw_if.run}, 16'h0000);
    chk_val("areset_dp", {12'h000, sw_if.dp_out}, 16'h0005);
    step(2);
    reset = 1'b1;
    step(8);
    chk_val("post_areset", w_disp, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
